axi_ram_slave: RTL and testbench

- AXI3 responder (slave) backed by an on-chip word-addressed RAM; the completion end of the CPU-side AXI master/crossbar path.
- Used as the memory model behind the CPU's external AXI port in simulation, and as a small on-chip RAM in FPGA builds.
- Serves one burst at a time, read or write, with round-robin arbitration between the AR and AW channels.
- Supports 32-bit beats only; FIXED, INCR and WRAP bursts; up to 16 beats.

---
 rtl/axi_ram_slave.sv | 170 +++++++++++++++++
 tb/tb_axi_ram_slave.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ram_slave.sv
// rtl/axi_ram_slave.sv - AXI3 single-burst responder backed by a word-addressed on-chip RAM.
// Serves one read or write burst at a time; AR/AW contention is resolved round-robin.
module axi_ram_slave #(
  parameter int ADDR_BITS = 12,
  parameter int ID_W      = 4
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic [ID_W-1:0] arid,
  input  logic [31:0]     araddr,
  input  logic [3:0]      arlen,
  input  logic [1:0]      arburst,
  input  logic            arvalid,
  output logic            arready,
  output logic [ID_W-1:0] rid,
  output logic [31:0]     rdata,
  output logic [1:0]      rresp,
  output logic            rlast,
  output logic            rvalid,
  input  logic            rready,
  input  logic [ID_W-1:0] awid,
  input  logic [31:0]     awaddr,
  input  logic [3:0]      awlen,
  input  logic [1:0]      awburst,
  input  logic            awvalid,
  output logic            awready,
  input  logic [ID_W-1:0] wid,
  input  logic [31:0]     wdata,
  input  logic [3:0]      wstrb,
  input  logic            wlast,
  input  logic            wvalid,
  output logic            wready,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp,
  output logic            bvalid,
  input  logic            bready
);

  typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;

  state_t                state, state_nxt;
  logic [31:0]           mem [0:(1<<ADDR_BITS)-1];
  logic [ADDR_BITS-1:0]  cur;
  logic [3:0]            cnt;
  logic [3:0]            len;
  logic [1:0]            burst;
  logic                  prio_rd;
  logic                  wlast_seen;
  logic [ID_W-1:0]       rid_q;
  logic [ID_W-1:0]       bid_q;
  logic [1:0]            bresp_q;
  logic                  final_beat;

  function automatic logic [ADDR_BITS-1:0] next_addr(
    input logic [ADDR_BITS-1:0] a,
    input logic [3:0]           l,
    input logic [1:0]           b
  );
    logic [ADDR_BITS-1:0] mask;
    logic [ADDR_BITS-1:0] inc;
    mask = ADDR_BITS'(l);
    inc  = a + ADDR_BITS'(1);
    next_addr = inc;
    if (b == 2'b00) begin
      next_addr = a;
    end else if (b == 2'b10 && (l == 4'd1 || l == 4'd3 || l == 4'd7 || l == 4'd15)) begin
      // Wrap keeps the block base and rolls only the low index bits.
      next_addr = (a & ~mask) | (inc & mask);
    end
  endfunction

  assign final_beat = (cnt == len);
  assign rlast      = (state == RD) && final_beat;
  assign rdata      = (state == RD) ? mem[cur] : 32'h0;
  assign rresp      = 2'b00;
  assign rid        = rid_q;
  assign bid        = bid_q;
  assign bresp      = bresp_q;

  always_comb begin
    state_nxt = state;
    arready   = 1'b0;
    awready   = 1'b0;
    rvalid    = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    case (state)
      IDLE: begin
        arready = arvalid & (~awvalid | prio_rd);
        awready = awvalid & (~arvalid | ~prio_rd);
        if (arready)      state_nxt = RD;
        else if (awready) state_nxt = WR;
      end
      RD: begin
        rvalid = 1'b1;
        if (rready && final_beat) state_nxt = IDLE;
      end
      WR: begin
        wready = 1'b1;
        if (wvalid && final_beat) state_nxt = WRESP;
      end
      WRESP: begin
        bvalid = 1'b1;
        if (bready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      cur        <= '0;
      cnt        <= 4'd0;
      len        <= 4'd0;
      burst      <= 2'b00;
      prio_rd    <= 1'b1;
      wlast_seen <= 1'b0;
      rid_q      <= '0;
      bid_q      <= '0;
      bresp_q    <= 2'b00;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (arready) begin
            rid_q <= arid;
            cur   <= araddr[ADDR_BITS+1:2];
            len   <= arlen;
            burst <= arburst;
            cnt   <= 4'd0;
          end else if (awready) begin
            bid_q      <= awid;
            cur        <= awaddr[ADDR_BITS+1:2];
            len        <= awlen;
            burst      <= awburst;
            cnt        <= 4'd0;
            wlast_seen <= 1'b0;
          end
          // The pointer only moves when both channels contended for the grant.
          if (arvalid && awvalid) prio_rd <= ~prio_rd;
        end
        RD: begin
          if (rready) begin
            cur <= next_addr(cur, len, burst);
            cnt <= cnt + 4'd1;
          end
        end
        WR: begin
          if (wvalid) begin
            cur <= next_addr(cur, len, burst);
            cnt <= cnt + 4'd1;
            if (final_beat) bresp_q <= (!wlast || wlast_seen) ? 2'b10 : 2'b00;
            else if (wlast) wlast_seen <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (state == WR && wvalid) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[cur][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_ram_slave.sv
// tb/tb_axi_ram_slave.sv - directed self-checking bench for axi_ram_slave.
module tb_axi_ram_slave;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  arid = 4'd0;
    logic [31:0] araddr = 32'h0;
    logic [3:0]  arlen = 4'd0;
    logic [1:0]  arburst = 2'b01;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [3:0]  awid = 4'd0;
    logic [31:0] awaddr = 32'h0;
    logic [3:0]  awlen = 4'd0;
    logic [1:0]  awburst = 2'b01;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [3:0]  wid = 4'd0;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  wstrb = 4'h0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] wbuf [16];
    logic [31:0] rexp [16];

    axi_ram_slave #(.ADDR_BITS(12), .ID_W(4)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ar_hs(input logic [31:0] addr, input logic [3:0] l,
                         input logic [3:0] id, input logic [1:0] b);
        araddr = addr; arlen = l; arid = id; arburst = b; arvalid = 1'b1;
        #1;
        for (int k = 0; k < 20 && arready !== 1'b1; k++) begin
            @(negedge aclk); #1;
        end
        chk("arready", 32'(arready), 32'd1);
        @(posedge aclk); @(negedge aclk);
        arvalid = 1'b0;
    endtask

    task automatic aw_hs(input logic [31:0] addr, input logic [3:0] l,
                         input logic [3:0] id, input logic [1:0] b);
        awaddr = addr; awlen = l; awid = id; awburst = b; awvalid = 1'b1;
        #1;
        for (int k = 0; k < 20 && awready !== 1'b1; k++) begin
            @(negedge aclk); #1;
        end
        chk("awready", 32'(awready), 32'd1);
        @(posedge aclk); @(negedge aclk);
        awvalid = 1'b0;
    endtask

    task automatic r_beats(input int n, input logic [3:0] id);
        for (int i = 0; i < n; i++) begin
            tests++;
            if (rvalid !== 1'b1) begin
                fails++;
                $error("FAIL rvalid: observed %0h expected 1", rvalid);
            end
            tests++;
            if (rdata !== rexp[i]) begin
                fails++;
                $error("FAIL rdata: observed %0h expected %0h", rdata, rexp[i]);
            end
            tests++;
            if (rid !== id) begin
                fails++;
                $error("FAIL rid: observed %0h expected %0h", rid, id);
            end
            tests++;
            if (rlast !== (i == n - 1)) begin
                fails++;
                $error("FAIL rlast: observed %0h expected %0h", rlast, (i == n - 1));
            end
            tests++;
            if (rresp !== 2'b00) begin
                fails++;
                $error("FAIL rresp: observed %0h expected 0", rresp);
            end
            @(posedge aclk); @(negedge aclk);
        end
        chk("rvalid_end", 32'(rvalid), 32'd0);
    endtask

    task automatic w_beats(input int n, input logic [3:0] strb, input int last_at,
                           input logic [3:0] id, input logic [1:0] exp_resp);
        for (int i = 0; i < n; i++) begin
            wdata = wbuf[i]; wstrb = strb; wlast = (i == last_at); wvalid = 1'b1;
            tests++;
            if (wready !== 1'b1) begin
                fails++;
                $error("FAIL wready: observed %0h expected 1", wready);
            end
            @(posedge aclk); @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("bvalid", 32'(bvalid), 32'd1);
        chk("bid", 32'(bid), 32'(id));
        chk("bresp", 32'(bresp), 32'(exp_resp));
        @(posedge aclk); @(negedge aclk);
        chk("bvalid_end", 32'(bvalid), 32'd0);
    endtask

    initial begin
        #12;
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rlast", 32'(rlast), 32'd0);
        chk("rst_wready", 32'(wready), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rid", 32'(rid), 32'd0);
        chk("rst_bid", 32'(bid), 32'd0);
        chk("rst_bresp", 32'(bresp), 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);

        araddr = 32'h300; arlen = 4'd0; arid = 4'd1; arburst = 2'b01; arvalid = 1'b1;
        awaddr = 32'h300; awlen = 4'd0; awid = 4'd3; awburst = 2'b01; awvalid = 1'b1;
        #1;
        chk("arb1_arready", 32'(arready), 32'd1);
        chk("arb1_awready", 32'(awready), 32'd0);
        ar_hs(32'h300, 4'd0, 4'd1, 2'b01);
        chk("arb1_rvalid", 32'(rvalid), 32'd1);
        chk("arb1_rid", 32'(rid), 32'd1);
        chk("arb1_rlast", 32'(rlast), 32'd1);
        @(posedge aclk); @(negedge aclk); #1;
        chk("arb1_awready_after", 32'(awready), 32'd1);
        wbuf[0] = 32'hCAFE0001;
        aw_hs(32'h300, 4'd0, 4'd3, 2'b01);
        w_beats(1, 4'hF, 0, 4'd3, 2'b00);

        araddr = 32'h300; arlen = 4'd0; arid = 4'd4; arburst = 2'b01; arvalid = 1'b1;
        awaddr = 32'h300; awlen = 4'd0; awid = 4'd6; awburst = 2'b01; awvalid = 1'b1;
        #1;
        chk("arb2_awready", 32'(awready), 32'd1);
        chk("arb2_arready", 32'(arready), 32'd0);
        wbuf[0] = 32'hCAFE0002;
        aw_hs(32'h300, 4'd0, 4'd6, 2'b01);
        w_beats(1, 4'hF, 0, 4'd6, 2'b00);
        rexp[0] = 32'hCAFE0002;
        ar_hs(32'h300, 4'd0, 4'd4, 2'b01);
        r_beats(1, 4'd4);

        wbuf[0] = 32'h11111111; wbuf[1] = 32'h22222222;
        wbuf[2] = 32'h33333333; wbuf[3] = 32'h44444444;
        aw_hs(32'h100, 4'd3, 4'd2, 2'b01);
        w_beats(4, 4'hF, 3, 4'd2, 2'b00);
        for (int i = 0; i < 4; i++) rexp[i] = wbuf[i];
        ar_hs(32'h100, 4'd3, 4'd5, 2'b01);
        r_beats(4, 4'd5);

        wbuf[0] = 32'h11111111;
        aw_hs(32'h200, 4'd0, 4'd1, 2'b01);
        w_beats(1, 4'hF, 0, 4'd1, 2'b00);
        wbuf[0] = 32'hAABBCCDD;
        aw_hs(32'h200, 4'd0, 4'd1, 2'b01);
        w_beats(1, 4'b0101, 0, 4'd1, 2'b00);
        rexp[0] = 32'h11BB11DD;
        ar_hs(32'h200, 4'd0, 4'd1, 2'b01);
        r_beats(1, 4'd1);

        wbuf[0] = 32'hA0; wbuf[1] = 32'hA1; wbuf[2] = 32'hA2; wbuf[3] = 32'hA3;
        aw_hs(32'h100, 4'd3, 4'd0, 2'b01);
        w_beats(4, 4'hF, 3, 4'd0, 2'b00);
        rexp[0] = 32'hA3; rexp[1] = 32'hA0; rexp[2] = 32'hA1; rexp[3] = 32'hA2;
        ar_hs(32'h10C, 4'd3, 4'd3, 2'b10);
        r_beats(4, 4'd3);

        ar_hs(32'h100, 4'd3, 4'd8, 2'b01);
        chk("bp_beat0", rdata, 32'hA0);
        @(posedge aclk); @(negedge aclk);
        rready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tests++;
            if (rvalid !== 1'b1) begin
                fails++;
                $error("FAIL bp_hold_rvalid: observed %0h expected 1", rvalid);
            end
            tests++;
            if (rdata !== 32'hA1) begin
                fails++;
                $error("FAIL bp_hold_rdata: observed %0h expected a1", rdata);
            end
            tests++;
            if (rlast !== 1'b0) begin
                fails++;
                $error("FAIL bp_hold_rlast: observed %0h expected 0", rlast);
            end
            tests++;
            if (rid !== 4'd8) begin
                fails++;
                $error("FAIL bp_hold_rid: observed %0h expected 8", rid);
            end
            @(posedge aclk); @(negedge aclk);
        end
        rready = 1'b1;
        rexp[0] = 32'hA1; rexp[1] = 32'hA2; rexp[2] = 32'hA3;
        r_beats(3, 4'd8);

        wbuf[0] = 32'h5; wbuf[1] = 32'h6;
        aw_hs(32'h400, 4'd1, 4'd7, 2'b01);
        w_beats(2, 4'hF, 0, 4'd7, 2'b10);

        ar_hs(32'h100, 4'd7, 4'd9, 2'b01);
        chk("rst_mid_beat0", rdata, 32'hA0);
        @(posedge aclk); @(negedge aclk);
        chk("rst_mid_beat1", rdata, 32'hA1);
        #2 aresetn = 1'b0;
        #1;
        chk("rst_mid_rvalid", 32'(rvalid), 32'd0);
        chk("rst_mid_rlast", 32'(rlast), 32'd0);
        chk("rst_mid_rid", 32'(rid), 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rst_mid_idle_rvalid", 32'(rvalid), 32'd0);
        for (int i = 0; i < 4; i++) rexp[i] = 32'hA0 + i;
        ar_hs(32'h100, 4'd3, 4'd9, 2'b01);
        r_beats(4, 4'd9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
